// File: rtl/irq_sched.sv
// Interrupt scheduler: synchronizes and registers the machine interrupt sources, then
// drains the pipeline before raising a trap request to WB. Also parks the core in WFI.
module irq_sched #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DRAIN_MAX   = 15
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       ext_irq_async,
  input  logic       timer_irq,
  input  logic       sw_irq,
  input  logic [2:0] mie_en,
  input  logic       mstatus_mie,
  input  logic [1:0] mode,
  input  logic       wfi,
  input  logic       pipe_empty,
  input  logic       trap_ack,
  output logic       meip,
  output logic       mtip,
  output logic       msip,
  output logic       hold_fetch,
  output logic       irq_req,
  output logic [3:0] irq_cause,
  output logic       sleeping,
  output logic       wake,
  output logic       drain_err
);

  typedef enum logic [1:0] {IDLE, DRAIN, REQ, SLEEP} state_t;

  localparam logic [7:0] DRAIN_LIM = 8'(DRAIN_MAX);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   mtip_q, msip_q;
  logic [7:0]             drain_cnt_q, drain_cnt_inc;
  logic [3:0]             cause_q, cause_sel;
  logic                   drain_err_q, wake_q;
  logic [2:0]             en;
  logic                   take;

  assign meip = sync_q[SYNC_STAGES-1];
  assign mtip = mtip_q;
  assign msip = msip_q;

  assign en   = {meip, mtip_q, msip_q} & mie_en;
  assign take = (|en) & ((mode != 2'b11) | mstatus_mie);

  // Software beats timer beats external when several enabled sources are pending.
  assign cause_sel = en[0] ? 4'd3 : (en[1] ? 4'd7 : 4'd11);

  assign drain_cnt_inc = (drain_cnt_q == 8'hFF) ? 8'hFF : drain_cnt_q + 8'd1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sync_q <= '0;
      mtip_q <= 1'b0;
      msip_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ext_irq_async};
      mtip_q <= timer_irq;
      msip_q <= sw_irq;
    end
  end

  // NOTE: state_d gets its default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take) state_d = DRAIN;
               else if (wfi) state_d = SLEEP;
      DRAIN:   if (!take) state_d = IDLE;
               else if (pipe_empty) state_d = REQ;
      REQ:     if (trap_ack) state_d = IDLE;
      SLEEP:   if (|en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q     <= IDLE;
      drain_cnt_q <= 8'd0;
      cause_q     <= 4'd0;
      drain_err_q <= 1'b0;
      wake_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      wake_q  <= (state_q == SLEEP) && (|en);
      if (state_q == IDLE && take) begin
        drain_cnt_q <= 8'd0;
        cause_q     <= cause_sel;
      end else if (state_q == DRAIN) begin
        drain_cnt_q <= drain_cnt_inc;
        // Sticky: a slow drain is reported but the request still waits for pipe_empty.
        if (drain_cnt_inc >= DRAIN_LIM) drain_err_q <= 1'b1;
      end
    end
  end

  assign hold_fetch = (state_q != IDLE);
  assign irq_req    = (state_q == REQ);
  assign sleeping   = (state_q == SLEEP);
  assign irq_cause  = cause_q;
  assign wake       = wake_q;
  assign drain_err  = drain_err_q;

endmodule

// File: tb/tb_irq_sched.sv
// Bench for irq_sched: directed scenarios plus random stimulus, scored against a
// cycle-level reference model through an expected-output queue and a cause queue.
module tb_irq_sched;

  localparam int SYNC = 2;
  localparam int DMAX = 3;
  localparam int P_IDLE = 0, P_DRAIN = 1, P_REQ = 2, P_SLEEP = 3;

  typedef struct packed {
    logic       meip, mtip, msip, hold, req;
    logic [3:0] cause;
    logic       sleeping, wake, err;
  } obs_t;

  logic       clk_in = 1'b0;
  logic       reset_in, ext_irq_async, timer_irq, sw_irq, mstatus_mie, wfi, pipe_empty, trap_ack;
  logic [2:0] mie_en;
  logic [1:0] mode;
  logic       meip, mtip, msip, hold_fetch, irq_req, sleeping, wake, drain_err;
  logic [3:0] irq_cause;

  int total = 0;
  int bad   = 0;

  obs_t exp_q[$];
  int   cause_q[$];

  irq_sched #(.SYNC_STAGES(SYNC), .DRAIN_MAX(DMAX)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .ext_irq_async(ext_irq_async),
    .timer_irq(timer_irq), .sw_irq(sw_irq), .mie_en(mie_en), .mstatus_mie(mstatus_mie),
    .mode(mode), .wfi(wfi), .pipe_empty(pipe_empty), .trap_ack(trap_ack),
    .meip(meip), .mtip(mtip), .msip(msip), .hold_fetch(hold_fetch), .irq_req(irq_req),
    .irq_cause(irq_cause), .sleeping(sleeping), .wake(wake), .drain_err(drain_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: interrupt sources delayed by their latency, a phase per the
  // scheduling rules, and a count of consecutive DRAIN cycles.
  logic [SYNC-1:0] m_hist = '0;
  logic            m_mtip = 0, m_msip = 0, m_err = 0, m_wake = 0;
  logic [2:0]      m_en;
  logic            m_take;
  int              m_phase = P_IDLE, m_cnt = 0, m_cause = 0;
  obs_t            m_obs;

  always @(posedge clk_in) begin
    if (reset_in) begin
      m_phase = P_IDLE; m_hist = '0; m_mtip = 0; m_msip = 0;
      m_cause = 0; m_cnt = 0; m_err = 0; m_wake = 0;
    end else begin
      m_en   = {m_hist[SYNC-1], m_mtip, m_msip} & mie_en;
      m_take = (m_en != 0) && (mode != 2'd3 || mstatus_mie);
      m_wake = 0;
      case (m_phase)
        P_IDLE:
          if (m_take) begin
            m_phase = P_DRAIN;
            m_cnt   = 0;
            m_cause = m_en[0] ? 3 : (m_en[1] ? 7 : 11);
          end else if (wfi) m_phase = P_SLEEP;
        P_DRAIN: begin
          m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
          if (m_cnt >= DMAX) m_err = 1;
          if (!m_take) m_phase = P_IDLE;
          else if (pipe_empty) begin
            m_phase = P_REQ;
            cause_q.push_back(m_cause);
          end
        end
        P_REQ:   if (trap_ack) m_phase = P_IDLE;
        default: if (m_en != 0) begin m_phase = P_IDLE; m_wake = 1; end
      endcase
      m_hist = {m_hist[SYNC-2:0], ext_irq_async};
      m_mtip = timer_irq;
      m_msip = sw_irq;
    end
    m_obs.meip     = m_hist[SYNC-1];
    m_obs.mtip     = m_mtip;
    m_obs.msip     = m_msip;
    m_obs.hold     = (m_phase != P_IDLE);
    m_obs.req      = (m_phase == P_REQ);
    m_obs.cause    = 4'(m_cause);
    m_obs.sleeping = (m_phase == P_SLEEP);
    m_obs.wake     = m_wake;
    m_obs.err      = m_err;
    exp_q.push_back(m_obs);
  end

  // Monitor: compares every presented output cycle, and the cause of each new request.
  obs_t act_obs, exp_obs;
  logic req_prev = 1'b0;

  always @(negedge clk_in) begin
    if (exp_q.size() > 0) begin
      exp_obs = exp_q.pop_front();
      act_obs = '{meip, mtip, msip, hold_fetch, irq_req, irq_cause, sleeping, wake, drain_err};
      check("outputs", 32'(act_obs), 32'(exp_obs));
      if (irq_req === 1'b1 && !req_prev) begin
        if (cause_q.size() == 0) check("cause_expected", 32'd0, 32'd1);
        else check("req_cause", 32'(irq_cause), 32'(cause_q.pop_front()));
      end
      req_prev = (irq_req === 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic wait_req(input string name, input int budget);
    for (int i = 0; i < budget && irq_req !== 1'b1; i++) tick();
    check(name, 32'(irq_req), 32'd1);
  endtask

  task automatic ack();
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
  endtask

  int wakes, reqs;

  initial begin
    reset_in = 1; ext_irq_async = 0; timer_irq = 0; sw_irq = 0; mie_en = 3'b000;
    mstatus_mie = 0; mode = 2'd0; wfi = 0; pipe_empty = 0; trap_ack = 0;
    tick(); tick();
    check("reset_outputs", 32'({meip, mtip, msip, hold_fetch, irq_req, irq_cause, sleeping, wake, drain_err}), 32'd0);
    reset_in = 0;

    // External interrupt timing through the synchronizer and drain.
    mode = 2'd3; mstatus_mie = 1; mie_en = 3'b100; pipe_empty = 1; ext_irq_async = 1;
    tick(); check("ext_meip_e1", 32'(meip), 32'd0);
    tick(); check("ext_meip_e2", 32'(meip), 32'd1); check("ext_hold_e2", 32'(hold_fetch), 32'd0);
    ext_irq_async = 0;
    tick(); check("ext_hold_e3", 32'(hold_fetch), 32'd1); check("ext_req_e3", 32'(irq_req), 32'd0);
    tick(); check("ext_req_e4", 32'(irq_req), 32'd1); check("ext_cause_e4", 32'(irq_cause), 32'd11);
    tick(); check("ext_req_e5", 32'(irq_req), 32'd1);
    ack();  check("ext_req_e6", 32'(irq_req), 32'd0);

    // Software beats timer; timer alone follows once software drops.
    mie_en = 3'b111; timer_irq = 1; sw_irq = 1;
    wait_req("prio_req1", 10); check("prio_cause3", 32'(irq_cause), 32'd3);
    sw_irq = 0; ack();
    wait_req("prio_req2", 10); check("prio_cause7", 32'(irq_cause), 32'd7);
    timer_irq = 0; ack();

    // Machine mode with mstatus.mie clear masks the timer until the mode drops.
    mode = 2'd3; mstatus_mie = 0; mie_en = 3'b010; timer_irq = 1;
    repeat (5) tick();
    check("masked_req", 32'(irq_req), 32'd0); check("masked_hold", 32'(hold_fetch), 32'd0);
    mode = 2'd0;
    wait_req("unmasked_req", 10); check("unmasked_cause", 32'(irq_cause), 32'd7);
    timer_irq = 0; mode = 2'd3; ack();

    // WFI sleep, then wake on a pending but globally disabled software interrupt.
    mie_en = 3'b001; tick();
    wfi = 1; tick(); wfi = 0;
    check("wfi_sleeping", 32'(sleeping), 32'd1); check("wfi_hold", 32'(hold_fetch), 32'd1);
    sw_irq = 1; wakes = 0; reqs = 0;
    repeat (6) begin tick(); wakes += int'(wake); reqs += int'(irq_req); end
    check("wake_pulses", 32'(wakes), 32'd1); check("wake_sleeping", 32'(sleeping), 32'd0);
    check("wake_no_req", 32'(reqs), 32'd0);
    sw_irq = 0; tick(); tick();

    // Slow drain raises the sticky error after DMAX cycles and still reaches REQ.
    mstatus_mie = 1; mie_en = 3'b010; pipe_empty = 0; timer_irq = 1;
    for (int i = 0; i < 10 && hold_fetch !== 1'b1; i++) tick();
    check("drain_entered", 32'(hold_fetch), 32'd1); check("drain_err_c0", 32'(drain_err), 32'd0);
    tick(); tick(); check("drain_err_c2", 32'(drain_err), 32'd0);
    tick(); check("drain_err_c3", 32'(drain_err), 32'd1); check("drain_no_req", 32'(irq_req), 32'd0);
    pipe_empty = 1;
    tick(); check("drain_req", 32'(irq_req), 32'd1); check("drain_err_req", 32'(drain_err), 32'd1);
    timer_irq = 0; ack(); tick(); check("drain_err_sticky", 32'(drain_err), 32'd1);

    // Reset while requesting aborts without an ack; the source re-enters afterwards.
    timer_irq = 1;
    wait_req("pre_reset_req", 10);
    reset_in = 1; tick();
    check("reset_in_req", 32'({meip, mtip, msip, hold_fetch, irq_req, irq_cause, sleeping, wake, drain_err}), 32'd0);
    reset_in = 0;
    wait_req("post_reset_req", 10);
    timer_irq = 0; ack();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset_in = ($urandom_range(249) == 0);
      if ($urandom_range(7) == 0) ext_irq_async = ~ext_irq_async;
      if ($urandom_range(5) == 0) timer_irq = ~timer_irq;
      if ($urandom_range(5) == 0) sw_irq = ~sw_irq;
      if ($urandom_range(9) == 0) mie_en = 3'($urandom);
      if ($urandom_range(9) == 0) mstatus_mie = 1'($urandom);
      if ($urandom_range(9) == 0) mode = 2'($urandom);
      wfi        = ($urandom_range(11) == 0);
      pipe_empty = ($urandom_range(3) != 0);
      trap_ack   = ($urandom_range(9) < 4);
      tick();
    end

    reset_in = 0; wfi = 0; trap_ack = 0; ext_irq_async = 0; timer_irq = 0; sw_irq = 0;
    tick(); tick();
    @(negedge clk_in); #1;
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    check("cause_queue_drained", 32'(cause_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
